// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage bus bridge.
package mem_stage_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // memsize encodings; any value with bit 1 set is a word access.
    localparam logic [1:0] MEMSIZE_BYTE = 2'b00;
    localparam logic [1:0] MEMSIZE_HALF = 2'b01;
    localparam logic [1:0] MEMSIZE_WORD = 2'b10;

    // Width of the bus timeout counter.
    localparam int CNT_W = 8;

    // Request attributes kept for the whole transaction so the load can be
    // extended from the original lane even if the core inputs move.
    typedef struct packed {
        logic [1:0] size;
        logic       uns;
        logic [1:0] lo;
    } req_attr_t;

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering: store byte enables and replication,
// load lane extraction with sign/zero extension, and alignment check.
module lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] shifted;

    // Move the addressed lane down to bit 0 (little-endian byte order).
    assign shifted = rdata_i >> {addr_i, 3'b000};

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    assign misalign_o = ((size_i == MEMSIZE_HALF) && addr_i[0]) ||
                        (size_i[1] && (addr_i != 2'b00));

    // Select enables, replicated store data and extended load data by size.
    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves a value unassigned and infers a latch.
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        if (size_i == MEMSIZE_BYTE) begin
            be_o    = 4'b0001 << addr_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = uns_i ? {24'b0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
        end else if (size_i == MEMSIZE_HALF) begin
            be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = uns_i ? {16'b0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: bridges the datapath load/store path onto a
// req/ack data bus, stalling the core while a transaction is in flight.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  memsize,
    input  logic        memunsigned,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        misalign,
    output logic        buserr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    req_attr_t        attr_q, attr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req;
    logic [1:0]  la_lo;
    logic [1:0]  la_size;
    logic        la_uns;
    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;
    logic        la_misalign;

    assign req = memread | memwrite;

    // In IDLE the lane logic looks at the live request; afterwards it uses
    // the attributes captured at the start of the transaction.
    assign la_lo   = (state_q == ST_IDLE) ? aluout[1:0] : attr_q.lo;
    assign la_size = (state_q == ST_IDLE) ? memsize     : attr_q.size;
    assign la_uns  = (state_q == ST_IDLE) ? memunsigned : attr_q.uns;

    lane_align u_lane_align (
        .addr_i     (la_lo),
        .size_i     (la_size),
        .uns_i      (la_uns),
        .wdata_i    (writedata),
        .rdata_i    (bus_rdata),
        .be_o       (la_be),
        .wdata_o    (la_wdata),
        .rdata_o    (la_rdata),
        .misalign_o (la_misalign)
    );

    // Next-state, datapath captures and handshake outputs.
    always_comb begin
        state_d    = state_q;
        readdata_d = readdata_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        attr_d     = attr_q;
        cnt_d      = cnt_q;
        stall      = 1'b0;
        misalign   = 1'b0;
        buserr     = 1'b0;
        bus_req    = 1'b0;

        // Outputs are held at their reset values while reset is asserted,
        // even if the core keeps presenting a request.
        if (reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (la_misalign) begin
                            misalign = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = ST_BUS;
                            addr_d  = {aluout[31:2], 2'b00};
                            be_d    = la_be;
                            wdata_d = la_wdata;
                            we_d    = memwrite;
                            attr_d  = '{size: memsize, uns: memunsigned,
                                        lo: aluout[1:0]};
                            cnt_d   = '0;
                        end
                    end
                end
                ST_BUS: begin
                    bus_req = 1'b1;
                    stall   = 1'b1;
                    if (bus_ack) begin
                        state_d = ST_DONE;
                        if (!we_q) begin
                            readdata_d = la_rdata;
                        end
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        buserr  = 1'b1;
                        state_d = ST_DONE;
                        if (!we_q) begin
                            readdata_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and latched bus fields, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            readdata_q <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            attr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            readdata_q <= readdata_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            attr_q     <= attr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign readdata  = readdata_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int TO = 6;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [1:0]  memsize;
    logic        memunsigned;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        misalign;
    logic        buserr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .memread     (memread),
        .memwrite    (memwrite),
        .memsize     (memsize),
        .memunsigned (memunsigned),
        .aluout      (aluout),
        .writedata   (writedata),
        .readdata    (readdata),
        .stall       (stall),
        .misalign    (misalign),
        .buserr      (buserr),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic bit f_misal(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == 2'd1 && lo[0]) || (sz >= 2'd2 && lo != 2'd0);
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'd0) return 4'(1 << lo);
        if (sz == 2'd1) return (lo >= 2'd2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w % 256) * 32'h01010101;
        if (sz == 2'd1) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] lo, input logic [31:0] r);
        logic [31:0] v;
        int          sh;
        sh = 8 * int'(lo);
        if (sz == 2'd0) begin
            v = (r >> sh) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (r >> sh) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    // Model state: 0 = waiting for a request, 1 = on the bus, 2 = retiring.
    int          m_phase = 0;
    int          m_wait  = 0;
    logic [31:0] m_addr  = '0;
    logic [3:0]  m_be    = '0;
    logic [31:0] m_wdata = '0;
    logic        m_we    = 1'b0;
    logic [1:0]  m_sz    = '0;
    logic        m_uns   = 1'b0;
    logic [1:0]  m_lo    = '0;
    logic [31:0] m_rd    = '0;

    // Compare every cycle on the falling edge, then advance the model to
    // what the next rising edge must produce.
    always @(negedge clk) begin
        logic e_stall, e_mis, e_err, e_req;
        if (!reset) begin
            check("rst_stall", stall, 0);
            check("rst_misalign", misalign, 0);
            check("rst_buserr", buserr, 0);
            check("rst_bus_req", bus_req, 0);
            check("rst_bus_we", bus_we, 0);
            check("rst_bus_addr", bus_addr, 0);
            check("rst_bus_be", bus_be, 0);
            check("rst_bus_wdata", bus_wdata, 0);
            check("rst_readdata", readdata, 0);
            m_phase = 0; m_wait = 0; m_addr = '0; m_be = '0; m_wdata = '0;
            m_we = 1'b0; m_sz = '0; m_uns = 1'b0; m_lo = '0; m_rd = '0;
        end else begin
            e_stall = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_req = 1'b0;
            if (m_phase == 0 && (memread || memwrite)) begin
                if (f_misal(memsize, aluout[1:0])) e_mis = 1'b1;
                else e_stall = 1'b1;
            end else if (m_phase == 1) begin
                e_req   = 1'b1;
                e_stall = 1'b1;
                if (!bus_ack && m_wait == TO) e_err = 1'b1;
            end
            check("stall", stall, e_stall);
            check("misalign", misalign, e_mis);
            check("buserr", buserr, e_err);
            check("bus_req", bus_req, e_req);
            check("bus_we", bus_we, m_we);
            check("bus_addr", bus_addr, m_addr);
            check("bus_be", bus_be, m_be);
            check("bus_wdata", bus_wdata, m_wdata);
            check("readdata", readdata, m_rd);

            if (m_phase == 0) begin
                if (e_stall) begin
                    m_addr  = {aluout[31:2], 2'b00};
                    m_be    = f_be(memsize, aluout[1:0]);
                    m_wdata = f_wdata(memsize, writedata);
                    m_we    = memwrite;
                    m_sz    = memsize;
                    m_uns   = memunsigned;
                    m_lo    = aluout[1:0];
                    m_wait  = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (bus_ack) begin
                    if (!m_we) m_rd = f_load(m_sz, m_uns, m_lo, bus_rdata);
                    m_phase = 2;
                end else if (m_wait == TO) begin
                    if (!m_we) m_rd = '0;
                    m_phase = 2;
                end else begin
                    m_wait++;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Run one aligned access; ack after 'delay' wait cycles (negative = never).
    // Returns with requests dropped, at the first cycle back in IDLE.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input int delay, input logic [31:0] rdat,
                              output int stall_cnt, output bit addr_stable,
                              output bit saw_err);
        logic [31:0] first_addr;
        memread = rd; memwrite = wr; memsize = sz; memunsigned = uns;
        aluout = a; writedata = wd; bus_ack = 1'b0; bus_rdata = $urandom;
        stall_cnt = 0; addr_stable = 1'b1; saw_err = 1'b0;
        #1;
        if (stall) stall_cnt++;
        cyc();
        first_addr = bus_addr;
        for (int i = 0; i < 40; i++) begin
            if (i == delay) begin
                bus_ack = 1'b1;
                bus_rdata = rdat;
            end
            #1;
            if (stall) stall_cnt++;
            if (bus_addr !== first_addr) addr_stable = 1'b0;
            if (buserr) saw_err = 1'b1;
            cyc();
            bus_ack = 1'b0;
            bus_rdata = $urandom;
            if (!bus_req) break;
        end
        check("acc_left_bus", bus_req, 0);
        memread = 1'b0; memwrite = 1'b0;
        #1;
        if (stall) stall_cnt++;
        cyc();
    endtask

    initial begin
        int sc;
        bit st, er;
        memread = 0; memwrite = 0; memsize = 0; memunsigned = 0;
        aluout = 0; writedata = 0; bus_ack = 0; bus_rdata = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("init_readdata", readdata, 32'h0);
        check("init_bus_req", bus_req, 0);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();

        // Word store with immediate ack: stall 1,1,0 over C0..C2.
        memwrite = 1; memsize = 2'b10; aluout = 32'h100; writedata = 32'hDEADBEEF;
        #1 check("ws_c0_stall", stall, 1);
        cyc();
        check("ws_c1_stall", stall, 1);
        check("ws_c1_req", bus_req, 1);
        check("ws_addr", bus_addr, 32'h100);
        check("ws_be", bus_be, 4'hF);
        check("ws_wdata", bus_wdata, 32'hDEADBEEF);
        check("ws_we", bus_we, 1);
        bus_ack = 1;
        cyc();
        bus_ack = 0; memwrite = 0;
        #1 check("ws_c2_stall", stall, 0);
        check("ws_c2_req", bus_req, 0);
        cyc();

        // Byte load at 0x103, signed then unsigned.
        run_access(1, 0, 2'b00, 0, 32'h103, 0, 0, 32'h80123456, sc, st, er);
        check("lb_signed", readdata, 32'hFFFFFF80);
        run_access(1, 0, 2'b00, 1, 32'h103, 0, 0, 32'h80123456, sc, st, er);
        check("lb_unsigned", readdata, 32'h00000080);

        // Half store at 0x102.
        run_access(0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 0, 0, sc, st, er);
        check("sh_be", bus_be, 4'hC);
        check("sh_wdata", bus_wdata, 32'hABCDABCD);
        check("sh_addr", bus_addr, 32'h100);
        check("sh_readdata_kept", readdata, 32'h00000080);

        // Misaligned half load at 0x101.
        memread = 1; memsize = 2'b01; memunsigned = 0; aluout = 32'h101;
        #1 check("mis_pulse", misalign, 1);
        check("mis_stall", stall, 0);
        check("mis_req", bus_req, 0);
        cyc();
        memread = 0;
        #1 check("mis_no_req", bus_req, 0);
        check("mis_readdata", readdata, 32'h00000080);
        cyc();

        // Ack after 5 wait cycles: 7 stall cycles, address stable.
        run_access(1, 0, 2'b10, 0, 32'h200, 0, 5, 32'hCAFEF00D, sc, st, er);
        check("dly_stall_cycles", sc, 7);
        check("dly_addr_stable", st, 1);
        check("dly_readdata", readdata, 32'hCAFEF00D);

        // Never ack: buserr on the (TO+1)th BUS cycle, readdata cleared.
        run_access(1, 0, 2'b01, 0, 32'h202, 0, -1, 0, sc, st, er);
        check("to_buserr", er, 1);
        check("to_stall_cycles", sc, TO + 2);
        check("to_readdata", readdata, 32'h0);

        // Ack exactly in the timeout cycle wins.
        run_access(1, 0, 2'b01, 1, 32'h202, 0, TO, 32'h80011234, sc, st, er);
        check("to_edge_no_err", er, 0);
        check("to_edge_readdata", readdata, 32'h00008001);

        // Reset in the middle of BUS.
        memread = 1; memsize = 2'b10; memunsigned = 0; aluout = 32'h300;
        cyc();
        #1 check("rmid_req_before", bus_req, 1);
        reset = 1'b0;
        #1 check("rmid_req", bus_req, 0);
        check("rmid_stall", stall, 0);
        check("rmid_addr", bus_addr, 32'h0);
        check("rmid_readdata", readdata, 32'h0);
        memread = 0;
        cyc();
        reset = 1'b1;
        cyc();
        run_access(1, 0, 2'b00, 1, 32'h001, 0, 2, 32'h0000AB00, sc, st, er);
        check("rmid_fresh_load", readdata, 32'h000000AB);
        run_access(0, 1, 2'b10, 0, 32'h004, 32'h55AA55AA, 1, 0, sc, st, er);
        check("store_keeps_rd", readdata, 32'h000000AB);

        // Randomized traffic, checked only by the model.
        for (int i = 0; i < 4000; i++) begin
            memread     = ($urandom % 3) == 0;
            memwrite    = ($urandom % 4) == 0;
            memsize     = 2'($urandom);
            memunsigned = 1'($urandom);
            aluout      = $urandom;
            writedata   = $urandom;
            bus_ack     = ($urandom % 4) == 0;
            bus_rdata   = $urandom;
            cyc();
        end
        memread = 0; memwrite = 0; bus_ack = 0;
        repeat (TO + 4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
